// File: rtl/enable_seq_pkg.sv
// enable_seq_pkg: shared types and helpers for the enable_sequencer block.
// The sequencer FSM states and the level-to-thermometer helper live here so
// the top level and any future siblings agree on encoding.
package enable_seq_pkg;

    // Upper bound on channel count supported by therm(); widen if needed.
    localparam int unsigned MAX_CHANNELS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } seq_state_t;

    // Thermometer code of lvl over n channels: bit k set when k < lvl.
    function automatic logic [MAX_CHANNELS-1:0] therm(input int unsigned lvl,
                                                      input int unsigned n);
        logic [MAX_CHANNELS-1:0] t;
        t = '0;
        for (int unsigned k = 0; k < MAX_CHANNELS; k++) begin
            if ((k < lvl) && (k < n)) begin
                t[k] = 1'b1;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/enable_sequencer_gate.sv
// enable_gate_reg: one channel's WIDTH-bit registered AND gate.
// The gate value is sampled from the sequencer's registered channel state,
// so data reaches the output one cycle after in, and one cycle after the
// channel turns on.
module enable_gate_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Register the gated data; reset forces the channel output low at once.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= d_i & {WIDTH{en_i}};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/enable_sequencer.sv
// enable_sequencer: soft-start/soft-stop gate for CHANNELS buses of WIDTH
// bits behind one shared enable. Channels turn on one at a time STEP_CYCLES
// apart and turn off in reverse order; a request reversal mid-ramp turns
// around immediately without losing a step.
// Optional feature: define ENABLE_SEQ_MASK_EN to add a ch_mask input that
// holds selected channels off while keeping their time slot in the sequence.
module enable_sequencer
    import enable_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int STEP_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
`ifdef ENABLE_SEQ_MASK_EN
    input  logic [CHANNELS-1:0]       ch_mask,
`endif
    input  logic [CHANNELS*WIDTH-1:0] in,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       ch_active,
    output logic                      busy,
    output logic                      done
);

    localparam int LVL_W = $clog2(CHANNELS + 1);
    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(CHANNELS);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    seq_state_t          state_q, state_d;
    logic [LVL_W-1:0]    lvl_q, lvl_d;
    logic [CNT_W-1:0]    step_cnt_q, step_cnt_d;
    logic [CHANNELS-1:0] ch_active_q, ch_active_d;
    logic                busy_q, done_q;

    logic [LVL_W-1:0]    lvl_inc, lvl_dec;

    assign lvl_inc = lvl_q + LVL_ONE;
    assign lvl_dec = lvl_q - LVL_ONE;

    // Next level, step count and state from the current state and request.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        lvl_d      = lvl_q;
        step_cnt_d = step_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    lvl_d      = LVL_ONE;
                    step_cnt_d = '0;
                    state_d    = (CHANNELS == 1) ? ON : UP;
                end
            end
            UP: begin
                if (enable) begin
                    if (step_cnt_q == CNT_LAST) begin
                        step_cnt_d = '0;
                        lvl_d      = lvl_inc;
                        if (lvl_inc == LVL_MAX) begin
                            state_d = ON;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + CNT_ONE;
                    end
                end else begin
                    // Reverse on this edge: drop the newest channel now.
                    lvl_d      = lvl_dec;
                    step_cnt_d = '0;
                    state_d    = (lvl_dec == '0) ? IDLE : DOWN;
                end
            end
            ON: begin
                if (!enable) begin
                    lvl_d      = LVL_MAX - LVL_ONE;
                    step_cnt_d = '0;
                    state_d    = (CHANNELS == 1) ? IDLE : DOWN;
                end
            end
            DOWN: begin
                if (!enable) begin
                    if (step_cnt_q == CNT_LAST) begin
                        step_cnt_d = '0;
                        lvl_d      = lvl_dec;
                        if (lvl_dec == '0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + CNT_ONE;
                    end
                end else begin
                    // Reverse on this edge: bring the last channel back now.
                    lvl_d      = lvl_inc;
                    step_cnt_d = '0;
                    state_d    = (lvl_inc == LVL_MAX) ? ON : UP;
                end
            end
            default: begin
                state_d    = IDLE;
                lvl_d      = '0;
                step_cnt_d = '0;
            end
        endcase
    end

    // Channel gate pattern for the next level; masked channels never open
    // but still occupy their slot because the level keeps counting.
`ifdef ENABLE_SEQ_MASK_EN
    assign ch_active_d = CHANNELS'(therm(32'(lvl_d), CHANNELS)) & ~ch_mask;
`else
    assign ch_active_d = CHANNELS'(therm(32'(lvl_d), CHANNELS));
`endif

    // FSM registers plus outputs registered from the next state so busy,
    // done and ch_active change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lvl_q       <= '0;
            step_cnt_q  <= '0;
            ch_active_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            step_cnt_q  <= step_cnt_d;
            ch_active_q <= ch_active_d;
            busy_q      <= (state_d == UP) || (state_d == DOWN);
            done_q      <= (state_d == ON);
        end
    end

    // One registered AND gate per channel, driven by the pre-edge gate state.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_gate
        enable_gate_reg #(
            .WIDTH (WIDTH)
        ) u_gate (
            .clk   (clk),
            .reset (reset),
            .en_i  (ch_active_q[k]),
            .d_i   (in[k*WIDTH +: WIDTH]),
            .q_o   (out[k*WIDTH +: WIDTH])
        );
    end

    assign ch_active = ch_active_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
